mem_access_ctrl: RTL

- Initiator-side controller for the unified instruction/data memory (`inst_mem`).
- Arbitrates between the fetch stage and the load/store unit (LSU) and drives the memory's address, enable and write-data inputs.
- Captures the memory's registered outputs and returns them to the requester with a one-cycle valid pulse.
- Enforces the memory map: data space is 0x0000–0x1FFF; instructions are fetched at MEM_BASE_ADDR + pc.

---
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the unified instruction/data memory: arbitrates
// fetch vs. LSU, drives the memory ports and returns registered responses.
module mem_access_ctrl #(
    parameter int ADDRESS_BUS_WIDTH = 14,
    parameter int INSTRUCTION_WIDTH = 18,
    parameter int DATA_WIDTH        = 36,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] MEM_BASE_ADDR = 14'h2000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_if_req,
    input  logic [ADDRESS_BUS_WIDTH-2:0] i_if_pc,
    output logic                         o_if_ready,
    output logic                         o_if_valid,
    output logic [INSTRUCTION_WIDTH-1:0] o_if_instruction,
    input  logic                         i_ls_req,
    input  logic                         i_ls_we,
    input  logic [ADDRESS_BUS_WIDTH-1:0] i_ls_addr,
    input  logic [DATA_WIDTH-1:0]        i_ls_wdata,
    output logic                         o_ls_ready,
    output logic                         o_ls_valid,
    output logic [DATA_WIDTH-1:0]        o_ls_rdata,
    output logic                         o_ls_err,
    output logic [ADDRESS_BUS_WIDTH-1:0] o_mem_address,
    output logic                         o_mem_writeEnable,
    output logic                         o_mem_dataReadEnable,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    input  logic [INSTRUCTION_WIDTH-1:0] i_mem_instruction,
    input  logic [DATA_WIDTH-1:0]        i_mem_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE, K_ERR} kind_t;

    state_t                         state_q;
    kind_t                          kind_q;
    logic                           fetch_turn_q;
    logic [ADDRESS_BUS_WIDTH-1:0]   mem_addr_q;
    logic                           mem_we_q;
    logic                           mem_re_q;
    logic [DATA_WIDTH-1:0]          mem_wdata_q;
    logic                           if_valid_q;
    logic [INSTRUCTION_WIDTH-1:0]   if_instr_q;
    logic                           ls_valid_q;
    logic [DATA_WIDTH-1:0]          ls_rdata_q;
    logic                           ls_err_q;

    logic                           idle;
    logic                           contest;
    logic                           if_grant;
    logic                           ls_grant;
    logic                           ls_illegal;
    logic [ADDRESS_BUS_WIDTH-1:0]   fetch_addr;

    // fetch_turn picks the winner only when both sides request; the LSU ready
    // is gated too so a losing LSU never sees a handshake it did not get.
    assign idle       = (state_q == IDLE);
    assign contest    = i_if_req & i_ls_req;
    assign o_if_ready = idle & (~i_ls_req | fetch_turn_q);
    assign o_ls_ready = idle & (~i_if_req | ~fetch_turn_q);
    assign if_grant   = o_if_ready & i_if_req;
    assign ls_grant   = o_ls_ready & i_ls_req;
    assign ls_illegal = (i_ls_addr >= MEM_BASE_ADDR);
    assign fetch_addr = MEM_BASE_ADDR + ADDRESS_BUS_WIDTH'(i_if_pc);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            kind_q       <= K_FETCH;
            fetch_turn_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            ls_valid_q   <= 1'b0;
            ls_rdata_q   <= '0;
            ls_err_q     <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_grant || ls_grant) begin
                        state_q <= ISSUE;
                        if (contest)
                            fetch_turn_q <= ~fetch_turn_q;
                        if (if_grant) begin
                            kind_q     <= K_FETCH;
                            mem_addr_q <= fetch_addr;
                        end else if (ls_illegal) begin
                            // Out-of-range access never reaches the memory.
                            kind_q <= K_ERR;
                        end else begin
                            kind_q      <= i_ls_we ? K_STORE : K_LOAD;
                            mem_addr_q  <= i_ls_addr;
                            mem_we_q    <= i_ls_we;
                            mem_re_q    <= ~i_ls_we;
                            mem_wdata_q <= i_ls_we ? i_ls_wdata : '0;
                        end
                    end
                end
                ISSUE: begin
                    state_q     <= RESP;
                    mem_addr_q  <= '0;
                    mem_we_q    <= 1'b0;
                    mem_re_q    <= 1'b0;
                    mem_wdata_q <= '0;
                end
                RESP: begin
                    state_q <= IDLE;
                    case (kind_q)
                        K_FETCH: begin
                            if_instr_q <= i_mem_instruction;
                            if_valid_q <= 1'b1;
                        end
                        K_LOAD: begin
                            ls_rdata_q <= i_mem_data;
                            ls_err_q   <= 1'b0;
                            ls_valid_q <= 1'b1;
                        end
                        K_STORE: begin
                            ls_err_q   <= 1'b0;
                            ls_valid_q <= 1'b1;
                        end
                        default: begin
                            ls_rdata_q <= '0;
                            ls_err_q   <= 1'b1;
                            ls_valid_q <= 1'b1;
                        end
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_address        = mem_addr_q;
    assign o_mem_writeEnable    = mem_we_q;
    assign o_mem_dataReadEnable = mem_re_q;
    assign o_mem_wdata          = mem_wdata_q;
    assign o_if_valid           = if_valid_q;
    assign o_if_instruction     = if_instr_q;
    assign o_ls_valid           = ls_valid_q;
    assign o_ls_rdata           = ls_rdata_q;
    assign o_ls_err             = ls_err_q;

endmodule
